// File: rtl/byp_pkg.sv
// Shared types and default constants for the bypass fault controller.
// Holds the FSM state encoding and the parameter defaults used by all blocks.
package byp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int N_SRC_DEF   = 4;
    localparam int CNT_W_DEF   = 14;
    localparam int ON_W_DEF    = 16;
    localparam int ON_TIME_DEF = 10000;

endpackage

// File: rtl/byp_fault_ctrl_if.sv
// Signal bundle between the bypass fault controller and its environment.
// master: drives timebase, commands, fault flags and thresholds.
// slave:  the controller; drives byp_con, trip_latched, trip_src, on_active.
interface byp_fault_ctrl_if
    import byp_pkg::*;
#(
    parameter int N_SRC = N_SRC_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    logic                   tick_1us;
    logic                   unit_reset;
    logic                   byp_cmd_rx;
    logic [N_SRC-1:0]       fault_in;
    logic [N_SRC-1:0]       src_en;
    logic [N_SRC*CNT_W-1:0] delay_tims;
    logic                   local_byp_en;
    logic                   byp_con;
    logic                   trip_latched;
    logic [N_SRC-1:0]       trip_src;
    logic                   on_active;

    modport master (
        output tick_1us, unit_reset, byp_cmd_rx, fault_in,
        output src_en, delay_tims, local_byp_en,
        input  byp_con, trip_latched, trip_src, on_active
    );

    modport slave (
        input  tick_1us, unit_reset, byp_cmd_rx, fault_in,
        input  src_en, delay_tims, local_byp_en,
        output byp_con, trip_latched, trip_src, on_active
    );

endinterface

// File: rtl/byp_qual_cnt.sv
// One fault source's qualify counter: counts ticks while the source is
// active, saturates at all-ones and flags qualification at its threshold.
// Ports: clk, rst, clr (unit clear), inc (tick edge while counting is
// allowed), fault, en, thr (threshold in ticks), qual (qualified flag).
module byp_qual_cnt #(
    parameter int CNT_W = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic             fault,
    input  logic             en,
    input  logic [CNT_W-1:0] thr,
    output logic             qual
);

    logic             active;
    logic [CNT_W-1:0] cnt;

    assign active = fault & en;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (!active) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // A zero threshold qualifies immediately, without waiting for a tick.
    assign qual = active & (cnt >= thr);

endmodule

// File: rtl/byp_fault_ctrl.sv
// Bypass fault controller: qualifies per-source faults over 1 us ticks,
// latches the trip, runs a local bypass on-time window, then holds.
// Ports: clk, rst (sync, active-high), bus (slave side of byp_fault_ctrl_if).
module byp_fault_ctrl
    import byp_pkg::*;
#(
    parameter int N_SRC   = N_SRC_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int ON_W    = ON_W_DEF,
    parameter int ON_TIME = ON_TIME_DEF
) (
    input logic                   clk,
    input logic                   rst,
    byp_fault_ctrl_if.slave       bus
);

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       tick_sr;
    logic             tick_edge;
    logic [N_SRC-1:0] qual;
    logic             any_qual;
    logic [ON_W-1:0]  on_cnt;
    logic [N_SRC-1:0] trip_src;
    logic             on_active;
    logic             trip_latched;

    // Tick arrives from another domain; two flops then rising-edge detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_sr <= 2'b00;
        end else begin
            tick_sr <= {tick_sr[0], bus.tick_1us};
        end
    end

    assign tick_edge = (tick_sr == 2'b01);

    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        byp_qual_cnt #(
            .CNT_W (CNT_W)
        ) u_qual (
            .clk   (clk),
            .rst   (rst),
            .clr   (bus.unit_reset),
            .inc   (tick_edge && (state == IDLE)),
            .fault (bus.fault_in[i]),
            .en    (bus.src_en[i]),
            .thr   (bus.delay_tims[i*CNT_W +: CNT_W]),
            .qual  (qual[i])
        );
    end

    assign any_qual = |qual;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (bus.unit_reset) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: if (any_qual) state_nxt = ON;
                ON:   if (on_cnt == '0) state_nxt = HOLD;
                HOLD: state_nxt = HOLD;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // trip_src captures only on the IDLE->ON edge; later faults are ignored.
    always_ff @(posedge clk) begin
        if (rst || bus.unit_reset) begin
            on_cnt   <= '0;
            trip_src <= '0;
        end else if (state == IDLE) begin
            if (any_qual) begin
                on_cnt   <= ON_W'(ON_TIME);
                trip_src <= qual;
            end
        end else if (state == ON) begin
            if (tick_edge && (on_cnt != '0)) begin
                on_cnt <= on_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        trip_latched = (state != IDLE);
        on_active    = (state == ON);
    end

    assign bus.trip_latched = trip_latched;
    assign bus.on_active    = on_active;
    assign bus.trip_src     = trip_src;
    assign bus.byp_con      = bus.byp_cmd_rx
                            | (bus.local_byp_en & on_active);

endmodule
